// File: rtl/io_pkg.sv
// io_pkg: shared defaults for the io output FIFO.
//   IO_DATA_W : default bus/port word width
//   IO_DEPTH  : default FIFO entries (power of two, >= 2)
//   IO_CNT_W  : width of the occupancy count for the default depth
package io_pkg;
  localparam int IO_DATA_W = 16;
  localparam int IO_DEPTH  = 4;
  localparam int IO_CNT_W  = $clog2(IO_DEPTH) + 1;
endpackage

// File: rtl/io_out_fifo_if.sv
// io_out_fifo_if: bus-side push and port-side show-ahead output of the FIFO.
//   bus/busWriteEn : word to capture and its push request
//   portReady      : consumer accepts portData this cycle
//   portData       : head word, portValid when the FIFO is not empty
//   master = bus producer and port consumer; slave = the FIFO
interface io_out_fifo_if #(parameter int DATA_W = io_pkg::IO_DATA_W);
  logic [DATA_W-1:0] bus;
  logic              busWriteEn;
  logic              portReady;
  logic [DATA_W-1:0] portData;
  logic              portValid;

  modport master (output bus, busWriteEn, portReady, input portData, portValid);
  modport slave  (input bus, busWriteEn, portReady, output portData, portValid);
endinterface

// File: rtl/io_fifo_mem.sv
// io_fifo_mem: DEPTH x DATA_W register array.
//   clk         : write clock
//   we/waddr/wdata : synchronous write port
//   raddr/rdata    : asynchronous read port
// Contents are deliberately not reset.
module io_fifo_mem import io_pkg::*; #(
  parameter int DATA_W = IO_DATA_W,
  parameter int DEPTH  = IO_DEPTH,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/io_out_fifo.sv
// io_out_fifo: show-ahead output FIFO between the system bus and an IO port.
//   clk, reset   : clock, async active-high reset
//   io (slave)   : bus/busWriteEn push side, portData/portValid/portReady pop side
//   clrOverflow  : synchronous clear of the sticky overflow flag
//   full, empty, count : occupancy status
//   overflow     : sticky, set when a push is dropped because the FIFO is full
module io_out_fifo import io_pkg::*; #(
  parameter int DATA_W = IO_DATA_W,
  parameter int DEPTH  = IO_DEPTH,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  io_out_fifo_if.slave  io,
  input  logic          clrOverflow,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          overflow
);
  logic [PW-1:0] wptr, rptr;
  logic          pop, push, drop;

  assign empty        = (count == '0);
  assign full         = (count == CW'(DEPTH));
  assign io.portValid = !empty;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign pop  = io.portValid & io.portReady;
  assign push = io.busWriteEn & (!full | pop);
  assign drop = io.busWriteEn & full & !pop;

  io_fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wptr),
    .wdata (io.bus),
    .raddr (rptr),
    .rdata (io.portData)
  );

  // Power-of-two depth: pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // A drop wins over a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            overflow <= 1'b0;
    else if (drop)        overflow <= 1'b1;
    else if (clrOverflow) overflow <= 1'b0;
  end
endmodule

// File: tb/tb_io_out_fifo.sv
module tb_io_out_fifo;
  import io_pkg::*;

  localparam int DW = IO_DATA_W;
  localparam int CW = IO_CNT_W;

  logic          clk = 1'b0;
  logic          reset;
  logic          clrOverflow;
  logic          full, empty, overflow;
  logic [CW-1:0] count;

  io_out_fifo_if #(.DATA_W(DW)) io ();

  io_out_fifo #(.DATA_W(DW), .DEPTH(IO_DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .io          (io),
    .clrOverflow (clrOverflow),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] sb [$];

  // Scoreboard: every accepted pop is compared against the oldest expected word.
  always @(negedge clk) begin
    if (!reset && io.portValid && io.portReady) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_pop: got %h, expected nothing (queue empty)", io.portData);
      end else begin
        logic [DW-1:0] exp;
        exp = sb.pop_front();
        if (io.portData !== exp) begin
          errors++;
          $display("FAIL sb_pop: got %h, expected %h", io.portData, exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] w, input bit expect_accept);
    io.bus = w;
    io.busWriteEn = 1'b1;
    if (expect_accept) sb.push_back(w);
    tick();
    io.busWriteEn = 1'b0;
    io.bus = 'x;
  endtask

  task automatic drain(input string name);
    int n = 0;
    io.portReady = 1'b1;
    while (io.portValid && n < 20) begin
      tick();
      n++;
    end
    io.portReady = 1'b0;
    checks++;
    if (io.portValid !== 1'b0 || empty !== 1'b1 || sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: portValid=%b empty=%b left=%0d cycles=%0d, expected empty and 0 left",
               name, io.portValid, empty, sb.size(), n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || count !== '0 || overflow !== 1'b0 || io.portValid !== 1'b0) begin
      errors++;
      $display("FAIL reset: empty=%b full=%b count=%0d ovf=%b valid=%b, expected 1 0 0 0 0",
               empty, full, count, overflow, io.portValid);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    push_word(16'h1234, 1);
    checks++;
    if (io.portValid !== 1'b1 || io.portData !== 16'h1234 || count !== CW'(1)) begin
      errors++;
      $display("FAIL single: valid=%b data=%h count=%0d, expected 1 1234 1",
               io.portValid, io.portData, count);
    end
    drain("single");
  endtask

  task automatic test_overflow_drain();
    for (int i = 1; i <= 4; i++) push_word(16'hA000 + 16'(i), 1);
    push_word(16'hA005, 0);
    checks++;
    if (full !== 1'b1 || count !== CW'(4) || overflow !== 1'b1 || io.portData !== 16'hA001) begin
      errors++;
      $display("FAIL overflow: full=%b count=%0d ovf=%b head=%h, expected 1 4 1 a001",
               full, count, overflow, io.portData);
    end
    drain("overflow");
  endtask

  task automatic test_full_push_pop();
    clrOverflow = 1'b1;
    tick();
    clrOverflow = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL clr_before_fpp: ovf=%b, expected 0", overflow);
    end
    for (int i = 1; i <= 4; i++) push_word(16'hB000 + 16'(i), 1);
    io.portReady = 1'b1;
    push_word(16'hBEEF, 1);
    io.portReady = 1'b0;
    checks++;
    if (count !== CW'(4) || full !== 1'b1 || overflow !== 1'b0 || io.portData !== 16'hB002) begin
      errors++;
      $display("FAIL full_push_pop: count=%0d full=%b ovf=%b head=%h, expected 4 1 0 b002",
               count, full, overflow, io.portData);
    end
    drain("full_push_pop");
  endtask

  task automatic test_back_to_back();
    io.portReady = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_word(16'hC000 + 16'(i), 1);
      checks++;
      if (count > CW'(1)) begin
        errors++;
        $display("FAIL b2b_count[%0d]: count=%0d, expected <= 1", i, count);
      end
    end
    tick();
    io.portReady = 1'b0;
    checks++;
    if (count !== '0 || sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_end: count=%0d left=%0d, expected 0 0", count, sb.size());
    end
  endtask

  task automatic test_clr_overflow();
    for (int i = 1; i <= 4; i++) push_word(16'hD000 + 16'(i), 1);
    push_word(16'hD005, 0);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL clr_set: ovf=%b, expected 1", overflow);
    end
    clrOverflow = 1'b1;
    tick();
    clrOverflow = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL clr_pulse: ovf=%b, expected 0", overflow);
    end
    clrOverflow = 1'b1;
    push_word(16'hD006, 0);
    clrOverflow = 1'b0;
    checks++;
    if (overflow !== 1'b1 || count !== CW'(4) || io.portData !== 16'hD001) begin
      errors++;
      $display("FAIL clr_vs_drop: ovf=%b count=%0d head=%h, expected 1 4 d001",
               overflow, count, io.portData);
    end
    clrOverflow = 1'b1;
    tick();
    clrOverflow = 1'b0;
    drain("clr_overflow");
  endtask

  task automatic test_mid_reset();
    for (int i = 1; i <= 3; i++) push_word(16'hE000 + 16'(i), 1);
    checks++;
    if (count !== CW'(3)) begin
      errors++;
      $display("FAIL mid_reset_pre: count=%0d, expected 3", count);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (empty !== 1'b1 || count !== '0 || io.portValid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_async: empty=%b count=%0d valid=%b, expected 1 0 0",
               empty, count, io.portValid);
    end
    #4 reset = 1'b0;
    sb.delete();
    tick();
    push_word(16'h0055, 1);
    checks++;
    if (io.portData !== 16'h0055 || count !== CW'(1) || io.portValid !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_push: data=%h count=%0d valid=%b, expected 0055 1 1",
               io.portData, count, io.portValid);
    end
    drain("mid_reset");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    clrOverflow = 1'b0;
    io.bus = '0;
    io.busWriteEn = 1'b0;
    io.portReady = 1'b0;
    test_reset();
    test_single();
    test_overflow_drain();
    test_full_push_pop();
    test_back_to_back();
    test_clr_overflow();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/io_out_fifo.md
IO_OUT_FIFO -- requirements
Module: io_out_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 16: width of bus word and port data.
REQ-002 SHALL have parameter DEPTH, default 4: FIFO entries; power of two, at least 2.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port bus  input  DATA_W  shared system data bus; sampled only when busWriteEn=1.
REQ-006 SHALL have port busWriteEn  input  1  push request: capture bus at this clock edge.
REQ-007 SHALL have port portReady  input  1  external consumer accepts portData this cycle.
REQ-008 SHALL have port clrOverflow  input  1  synchronous clear of the overflow flag.
REQ-009 SHALL have port portData  output  DATA_W  FIFO head word (show-ahead).
REQ-010 SHALL have port portValid  output  1  portData holds a valid word (=!empty).
REQ-011 SHALL have port full  output  1  count==DEPTH.
REQ-012 SHALL have port empty  output  1  count==0.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  number of stored words.
REQ-014 SHALL have port overflow  output  1  sticky: a push was dropped.

Function
REQ-015 SHALL define pop = portValid & portReady, evaluated combinationally each cycle.
REQ-016 SHALL define push = busWriteEn & (!full | pop).
REQ-017 SHALL write bus into the tail entry and advance the write pointer, modulo DEPTH, at the edge when push=1.
REQ-018 SHALL advance the read pointer, modulo DEPTH, at the edge when pop=1; portData SHALL show the next entry in the following cycle.
REQ-019 SHALL have latency 1: a word pushed at edge N SHALL appear on portData with portValid=1 after edge N when the FIFO was empty.
REQ-020 SHALL update count by +1 on push only, -1 on pop only, and 0 on both or neither.
REQ-021 SHALL, when full and busWriteEn=1 with pop=1, accept the push so that count stays DEPTH with no data loss.
REQ-022 SHALL, when full and busWriteEn=1 with pop=0, drop the word, leave storage and pointers unchanged, and set overflow at that edge.
REQ-023 SHALL, when empty and busWriteEn=1, perform no pop because portValid=0, regardless of portReady.
REQ-024 SHALL clear overflow at an edge with clrOverflow=1, unless a drop occurs at the same edge, in which case overflow SHALL remain 1.
REQ-025 SHALL let the pointers wrap DEPTH-1 -> 0 without a bubble or loss of ordering.
REQ-026 SHALL drive portData to the head storage entry; its value is don't-care when portValid=0, and bus X/Z values SHALL NOT affect state when busWriteEn=0.

Reset
REQ-027 SHALL, on reset=1 and asynchronously, clear the pointers, count=0, overflow=0, empty=1, full=0, portValid=0.
REQ-028 SHALL NOT be required to clear storage contents on reset; portData is don't-care until the first push.
REQ-029 SHALL, on reset asserted mid-operation, discard all stored words; the first push after deassertion SHALL land in entry 0.

Structure
REQ-030 SHALL take DATA_W and DEPTH defaults from shared package io_pkg, which also holds the count-width constant.
REQ-031 SHALL place storage in sub-module io_fifo_mem: a DEPTH x DATA_W register array with one synchronous write port and one asynchronous read port; pointers, count and flags stay in io_out_fifo.

Verification
REQ-032 SHALL cover this case: after reset, push 0x1234 with portReady=0 -> the next cycle shows portValid=1, portData=0x1234, count=1.
REQ-033 SHALL cover this case: push 0xA001..0xA004 with portReady=0, then push 0xA005 -> full=1, count=4, overflow=1, head=0xA001; draining yields A001..A004 in order.
REQ-034 SHALL cover this case: when full, busWriteEn=1 with bus=0xBEEF and portReady=1 at the same edge -> count=4, overflow=0, 0xBEEF is drained last.
REQ-035 SHALL cover this case: 10 back-to-back pushes with portReady=1 -> 10 words out in order, count never exceeds 1, the pointers wrap twice.
REQ-036 SHALL cover this case: overflow=1 with clrOverflow pulsed for one cycle -> overflow=0; a drop and clrOverflow at the same edge -> overflow stays 1.
REQ-037 SHALL cover this case: with count=3, reset asserted for half a cycle mid-clock -> empty=1, count=0 immediately; then push 0x0055 -> portData=0x0055.
